fifo_sync: RTL
==============

# fifo_sync

Synchronous first-in/first-out buffer for the experiment #4 datapath. It sits directly downstream of the reset conditioner: its reset input is the conditioned, active-high version of the board reset, and all of its state is cleared by it. It provides word storage with full/empty status, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 8: width of each stored word.
- DEPTH, 16: number of entries. Must be a power of two and at least 4.
- AF_LEVEL, 12: ALMOST_FULL asserts when COUNT is at least this value.
- AE_LEVEL, 4: ALMOST_EMPTY asserts when COUNT is at most this value.

Ports:
- CLK  input  1  single clock; all logic is on the rising edge.
- RST  input  1  asynchronous, active-high reset (already decided). Assertion clears state immediately; release is synchronous to CLK because it is driven by the conditioned reset.
- WR_EN  input  1  write request.
- DIN  input  DATA_WIDTH  write data.
- RD_EN  input  1  read request.
- DOUT  output  DATA_WIDTH  registered read data.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- ALMOST_FULL  output  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  output  1  COUNT <= AE_LEVEL.
- COUNT  output  $clog2(DEPTH+1)  current occupancy.
- OVERFLOW  output  1  sticky; set when a write is rejected.
- UNDERFLOW  output  1  sticky; set when a read is rejected.

## Operation
- Write accepted (wr_ok) = WR_EN && (!FULL || rd_ok).
  - DIN is stored at the write pointer.
  - The write pointer increments modulo DEPTH.
- Read accepted (rd_ok) = RD_EN && !EMPTY.
  - DOUT is loaded from the read pointer.
  - The read pointer increments modulo DEPTH.
  - No fall-through: a read issued while EMPTY is rejected even if a write happens in the same cycle.
- COUNT update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- Pointers are $clog2(DEPTH) bits with natural wrap. FULL/EMPTY derive from the registered COUNT, not from pointer compare.
- All flags are registered. They are computed from the next COUNT, so they are consistent with COUNT in the same cycle.
- Error flags:
  - OVERFLOW sets when WR_EN && !wr_ok.
  - UNDERFLOW sets when RD_EN && !rd_ok.
  - Both stay set until RST.
  - Rejected operations change no other state.
- DOUT holds its last value when no read is accepted.
- Reset values:
  - Pointers = 0, COUNT = 0, DOUT = 0.
  - EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0.
  - OVERFLOW = 0, UNDERFLOW = 0.
  - Storage array is not reset.

## Timing
- Write-to-read latency: a word written at edge N is readable (EMPTY = 0) after edge N. An RD_EN sampled at edge N+1 places the word on DOUT after edge N+1.
- Read latency: DOUT is valid one cycle after the accepting edge.
- Simultaneous read and write:
  - When FULL: both accepted; COUNT stays at DEPTH.
  - When EMPTY: write only; COUNT goes to 1.
- Wrap-around: after DEPTH writes, the write pointer returns to 0. Data order is preserved across any number of wraps.
- Reset mid-operation: RST assertion forces reset values asynchronously within the same cycle. Contents are considered lost. The first operation is honoured on the first rising edge after RST is low.

## Structure
- Shared package fifo_pkg holds:
  - Default constants DATA_WIDTH_DEF = 8, DEPTH_DEF = 16, AF_LEVEL_DEF = 12, AE_LEVEL_DEF = 4.
  - A function for count width.
- Sub-module fifo_mem: a DEPTH x DATA_WIDTH register array with one write port (we, waddr, wdata). It has one synchronous read port (re, raddr, rdata registered, reset to 0 by RST).
- fifo_sync top holds pointers, COUNT, the flag registers, and the accept logic.

## Test plan
- Reset check: assert RST mid-stream with 5 words stored -> COUNT = 0, EMPTY = 1, DOUT = 0, error flags 0, all immediately without waiting for a clock edge.
- Fill and drain: write 0x01..0x10 (16 words) -> FULL = 1 after the 16th edge, ALMOST_FULL from COUNT = 12. Then read 16 times -> DOUT sequence 0x01..0x10, EMPTY = 1 at the end, ALMOST_EMPTY from COUNT = 4.
- Overflow: write while FULL with RD_EN = 0 -> OVERFLOW = 1 and sticky. COUNT stays 16 and stored data is unchanged (next read returns 0x01).
- Underflow: read while EMPTY with a simultaneous write of 0xAA -> UNDERFLOW = 1, COUNT = 1, DOUT unchanged. The next read returns 0xAA.
- Simultaneous on full: with FULL, apply WR_EN + RD_EN with DIN = 0x55 -> COUNT stays 16, DOUT = oldest word, 0x55 emerges 16 reads later.
- Wrap stress: 100 random-interleaved operations against a reference queue model -> DOUT, COUNT and all flags match every cycle across multiple pointer wraps.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int AF_LEVEL_DEF   = 12;
  localparam int AE_LEVEL_DEF   = 4;

  // COUNT must be able to represent DEPTH itself, hence depth+1.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one write port, one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; its contents are meaningless after RST.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO: pointers, occupancy, registered status flags and accept logic.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_LEVEL   = AF_LEVEL_DEF,
  parameter int AE_LEVEL   = AE_LEVEL_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WR_EN,
  input  logic [DATA_WIDTH-1:0]         DIN,
  input  logic                          RD_EN,
  output logic [DATA_WIDTH-1:0]         DOUT,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic                          ALMOST_FULL,
  output logic                          ALMOST_EMPTY,
  output logic [count_width(DEPTH)-1:0] COUNT,
  output logic                          OVERFLOW,
  output logic                          UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [CW-1:0] count_p1;
  logic          full_p1, empty_p1, afull_p1, aempty_p1;
  logic          ovf_p1, unf_p1;

  logic          wr_ok_p0, rd_ok_p0;
  logic [CW-1:0] count_nxt_p0;

  // Stage p0: accept decisions from registered status. A read needs stored
  // data (no fall-through); a write into a full FIFO rides on a same-cycle read.
  always_comb begin
    rd_ok_p0     = RD_EN && !empty_p1;
    wr_ok_p0     = WR_EN && (!full_p1 || rd_ok_p0);
    count_nxt_p0 = count_p1;
    case ({wr_ok_p0, rd_ok_p0})
      2'b10:   count_nxt_p0 = count_p1 + CW'(1);
      2'b01:   count_nxt_p0 = count_p1 - CW'(1);
      default: count_nxt_p0 = count_p1;
    endcase
  end

  // Stage p1: pointers, occupancy and flags; flags follow the next count so
  // they always agree with COUNT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
      full_p1   <= 1'b0;
      empty_p1  <= 1'b1;
      afull_p1  <= 1'b0;
      aempty_p1 <= 1'b1;
      ovf_p1    <= 1'b0;
      unf_p1    <= 1'b0;
    end else begin
      if (wr_ok_p0) wr_ptr_p1 <= wr_ptr_p1 + AW'(1);
      if (rd_ok_p0) rd_ptr_p1 <= rd_ptr_p1 + AW'(1);
      count_p1  <= count_nxt_p0;
      full_p1   <= (count_nxt_p0 == CW'(DEPTH));
      empty_p1  <= (count_nxt_p0 == '0);
      afull_p1  <= (count_nxt_p0 >= CW'(AF_LEVEL));
      aempty_p1 <= (count_nxt_p0 <= CW'(AE_LEVEL));
      if (WR_EN && !wr_ok_p0) ovf_p1 <= 1'b1;
      if (RD_EN && !rd_ok_p0) unf_p1 <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .RST   (RST),
    .we    (wr_ok_p0),
    .waddr (wr_ptr_p1),
    .wdata (DIN),
    .re    (rd_ok_p0),
    .raddr (rd_ptr_p1),
    .rdata (DOUT)
  );

  assign COUNT        = count_p1;
  assign FULL         = full_p1;
  assign EMPTY        = empty_p1;
  assign ALMOST_FULL  = afull_p1;
  assign ALMOST_EMPTY = aempty_p1;
  assign OVERFLOW     = ovf_p1;
  assign UNDERFLOW    = unf_p1;

endmodule
